// File: rtl/store_seq_ctl.sv
// store_seq_ctl: load/store sequencer for a single-port synchronous-read word RAM.
// Sub-word stores are read-modify-write; define STORE_SEQ_CACHE_EN for a one-entry word cache.
module store_seq_ctl #(
   parameter int N  = 32,
   parameter int AW = 32
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          req_i,
   input  logic          we_i,
   input  logic [3:0]    funct_i,
   input  logic [AW-1:0] addr_i,
   input  logic [N-1:0]  wdata_i,
   output logic          ready_o,
   output logic          done_o,
   output logic          err_o,
   output logic [N-1:0]  rdata_o,
   output logic          mem_re_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [N-1:0]  mem_wdata_o,
   input  logic [N-1:0]  mem_rdata_i
);

   typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;

   state_t        state;
   logic          we_q;
   logic [3:0]    funct_q;
   logic [1:0]    off_q;
   logic [N-1:0]  wdata_q;
   logic          err_q;
   logic          req_err;
   logic          hit;
   logic [N-1:0]  rdsrc;
   logic [N-1:0]  merged;
   logic [N-1:0]  shifted;
   logic [N-1:0]  load_val;

   always_comb begin
      req_err = 1'b1;
      case (funct_i)
         4'd0:    req_err = 1'b0;
         4'd1:    req_err = addr_i[0];
         4'd2:    req_err = (addr_i[1:0] != 2'b00);
         4'd4:    req_err = we_i;
         4'd5:    req_err = we_i | addr_i[0];
         default: req_err = 1'b1;
      endcase
   end

`ifdef STORE_SEQ_CACHE_EN
   logic          accept;
   logic          cache_valid;
   logic [AW-3:0] cache_tag;
   logic [N-1:0]  cache_data;
   logic          hit_q;

   assign accept = req_i && (state == IDLE);
   assign hit    = cache_valid && (cache_tag == addr_i[AW-1:2]);
   assign rdsrc  = hit_q ? cache_data : mem_rdata_i;

   // The block is the only RAM master, so the entry always mirrors the RAM word.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cache_valid <= 1'b0;
         cache_tag   <= '0;
         cache_data  <= '0;
         hit_q       <= 1'b0;
      end else begin
         if (accept)
            hit_q <= hit;
         if (state == CAP) begin
            cache_valid <= 1'b1;
            cache_tag   <= mem_addr_o[AW-1:2];
            cache_data  <= rdsrc;
         end
         if (state == WR) begin
            cache_valid <= 1'b1;
            cache_tag   <= mem_addr_o[AW-1:2];
            cache_data  <= mem_wdata_o;
         end
      end
   end
`else
   assign hit   = 1'b0;
   assign rdsrc = mem_rdata_i;
`endif

   always_comb begin
      merged = rdsrc;
      case (funct_q)
         4'd0:    merged[{off_q, 3'b000} +: 8]     = wdata_q[7:0];
         4'd1:    merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         default: merged = wdata_q;
      endcase
   end

   always_comb begin
      shifted  = rdsrc >> {off_q, 3'b000};
      load_val = shifted;
      case (funct_q)
         4'd0:    load_val = {{(N-8){shifted[7]}}, shifted[7:0]};
         4'd1:    load_val = {{(N-16){shifted[15]}}, shifted[15:0]};
         4'd4:    load_val = {{(N-8){1'b0}}, shifted[7:0]};
         4'd5:    load_val = {{(N-16){1'b0}}, shifted[15:0]};
         default: load_val = shifted;
      endcase
   end

   // Errors go straight to DONE; word stores need no read; cache hits skip RD.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         we_q       <= 1'b0;
         funct_q    <= '0;
         off_q      <= '0;
         wdata_q    <= '0;
         err_q      <= 1'b0;
         rdata_o    <= '0;
         mem_addr_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_i) begin
                  we_q       <= we_i;
                  funct_q    <= funct_i;
                  off_q      <= addr_i[1:0];
                  wdata_q    <= wdata_i;
                  err_q      <= req_err;
                  mem_addr_o <= {addr_i[AW-1:2], 2'b00};
                  if (req_err)
                     state <= DONE;
                  else if (we_i && (funct_i == 4'd2))
                     state <= WR;
                  else if (hit)
                     state <= we_i ? WR : CAP;
                  else
                     state <= RD;
               end
            end
            RD:      state <= we_q ? WR : CAP;
            CAP: begin
               rdata_o <= load_val;
               state   <= DONE;
            end
            WR:      state <= DONE;
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign ready_o     = (state == IDLE);
   assign mem_re_o    = (state == RD) && !rst_i;
   assign mem_we_o    = (state == WR) && !rst_i;
   assign done_o      = (state == DONE) && !rst_i;
   assign err_o       = done_o && err_q;
   assign mem_wdata_o = mem_we_o ? merged : '0;

endmodule

// File: tb/tb_store_seq_ctl.sv
// tb_store_seq_ctl: randomized scoreboard bench for store_seq_ctl with a word-level reference model.
// Build with STORE_SEQ_CACHE_EN defined to model the one-entry cache timing as well.
module tb_store_seq_ctl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_i;
   logic        we_i;
   logic [3:0]  funct_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        ready_o;
   logic        done_o;
   logic        err_o;
   logic [31:0] rdata_o;
   logic        mem_re_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata = '0;

   store_seq_ctl #(.N(32), .AW(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i),
      .funct_i(funct_i), .addr_i(addr_i), .wdata_i(wdata_i),
      .ready_o(ready_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
      .mem_re_o(mem_re_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      bit          is_load;
      bit          err;
      logic [31:0] rdata;
      logic [31:0] waddr;
      logic [31:0] wword;
      int          lat;
      int          re_n;
      int          we_n;
      int          acc;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          re_seen = 0;
   int          we_seen = 0;
   int          we_total = 0;

   // RAM covering byte addresses 0x100..0x1FF, plus a poke port for setup
   logic [31:0] ram [0:63];
   logic        poke_en;
   logic [5:0]  poke_idx;
   logic [31:0] poke_val;

   // Reference model state
   logic [31:0] ref_mem [0:63];
   bit          c_valid = 1'b0;
   logic [29:0] c_tag = '0;
   logic [31:0] last_rdata = '0;

   always @(posedge clk_i) cyc <= cyc + 1;

   always @(posedge clk_i) begin
      if (poke_en) ram[poke_idx] <= poke_val;
      if (mem_we_o) ram[mem_addr_o[7:2]] <= mem_wdata_o;
      if (mem_re_o) mem_rdata <= ram[mem_addr_o[7:2]];
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic bit model_err(input bit we, input int f, input int off);
      case (f)
         0:       return 1'b0;
         1:       return (off % 2) != 0;
         2:       return off != 0;
         4:       return we;
         5:       return we || ((off % 2) != 0);
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] word, input int f, input int off);
      longint v;
      case (f)
         0, 4:    v = longint'((word >> (8 * off)) & 32'h0000_00FF);
         1, 5:    v = longint'((word >> (8 * off)) & 32'h0000_FFFF);
         default: v = longint'(word);
      endcase
      if (f == 0 && v >= 128)   v = v - 256;
      if (f == 1 && v >= 32768) v = v - 65536;
      return 32'(v);
   endfunction

   function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] wd,
                                               input int f, input int off);
      logic [31:0] mask;
      case (f)
         0:       mask = 32'h0000_00FF << (8 * off);
         1:       mask = 32'h0000_FFFF << (8 * off);
         default: mask = 32'hFFFF_FFFF;
      endcase
      return (old & ~mask) | ((wd << (8 * off)) & mask);
   endfunction

   // Monitor: strobe sanity on every cycle, full comparison on each done pulse
   always @(negedge clk_i) begin
      if (mem_re_o || mem_we_o) begin
         checkOutput("strobe_exclusive", 32'(mem_re_o && mem_we_o), 32'd0);
      end
      if (mem_we_o) we_total++;
      if (rst_i) begin
         re_seen = 0;
         we_seen = 0;
      end else begin
         if (mem_re_o) begin
            re_seen++;
            if (sb_q.size() > 0) checkOutput("re_addr", mem_addr_o, sb_q[0].waddr);
         end
         if (mem_we_o) begin
            we_seen++;
            if (sb_q.size() > 0) begin
               checkOutput("we_addr", mem_addr_o, sb_q[0].waddr);
               checkOutput("we_data", mem_wdata_o, sb_q[0].wword);
            end
         end
         if (!done_o && err_o) checkOutput("err_without_done", 32'(err_o), 32'd0);
         if (done_o) begin
            if (sb_q.size() == 0) begin
               checkOutput("unexpected_done", 32'(done_o), 32'd0);
            end else begin
               mon_e = sb_q.pop_front();
               checkOutput("err", 32'(err_o), 32'(mon_e.err));
               checkOutput("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
               checkOutput("rdata", rdata_o, mon_e.rdata);
               checkOutput("re_count", 32'(re_seen), 32'(mon_e.re_n));
               checkOutput("we_count", 32'(we_seen), 32'(mon_e.we_n));
            end
            re_seen = 0;
            we_seen = 0;
         end
      end
   end

   task automatic poke(input int idx, input logic [31:0] val);
      @(negedge clk_i);
      poke_en  = 1'b1;
      poke_idx = idx[5:0];
      poke_val = val;
      @(negedge clk_i);
      poke_en  = 1'b0;
      ref_mem[idx] = val;
   endtask

   task automatic applyReset();
      @(negedge clk_i);
      req_i = 1'b0;
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      c_valid    = 1'b0;
      last_rdata = '0;
   endtask

   task automatic drain();
      int n = 0;
      req_i = 1'b0;
      while ((sb_q.size() != 0 || !ready_o) && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      checkOutput("drain_pending", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
   endtask

   // Issue one request; the model computes the expected response at issue time
   task automatic applyStimulus(input bit we, input logic [3:0] f, input logic [31:0] a,
                                input logic [31:0] wd, input bit hold);
      exp_t e;
      int   n = 0;
      int   idx;
      int   off;
      bit   hit;
      @(negedge clk_i);
      while (!ready_o && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      if (!ready_o) begin
         checkOutput("ready_wait", 32'(ready_o), 32'd1);
         req_i = 1'b0;
         return;
      end
      we_i = we; funct_i = f; addr_i = a; wdata_i = wd; req_i = 1'b1;
      idx = int'(a[7:2]);
      off = int'(a[1:0]);
      e.acc     = cyc;
      e.is_load = !we;
      e.err     = model_err(we, int'(f), off);
      e.waddr   = {a[31:2], 2'b00};
      e.wword   = '0;
      e.rdata   = last_rdata;
      if (e.err) begin
         e.lat = 1; e.re_n = 0; e.we_n = 0;
      end else begin
         hit = 1'b0;
`ifdef STORE_SEQ_CACHE_EN
         hit = c_valid && (c_tag == a[31:2]) && !(we && f == 4'd2);
`endif
         if (we && f == 4'd2) begin
            e.lat = 2; e.re_n = 0;
         end else if (hit) begin
            e.lat = 2; e.re_n = 0;
         end else begin
            e.lat = 3; e.re_n = 1;
         end
         e.we_n = we ? 1 : 0;
         if (we) begin
            e.wword      = model_store(ref_mem[idx], wd, int'(f), off);
            ref_mem[idx] = e.wword;
         end else begin
            last_rdata = model_load(ref_mem[idx], int'(f), off);
            e.rdata    = last_rdata;
         end
         c_valid = 1'b1;
         c_tag   = a[31:2];
      end
      sb_q.push_back(e);
      @(posedge clk_i);
      #1;
      if (!hold) req_i = 1'b0;
   endtask

   initial begin
      int          we_before;
      logic [3:0]  f;
      logic [31:0] a;
      int          r;
      rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; funct_i = '0; addr_i = '0; wdata_i = '0;
      poke_en = 1'b0; poke_idx = '0; poke_val = '0;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      checkOutput("reset_ready", 32'(ready_o), 32'd1);
      checkOutput("reset_done", 32'(done_o), 32'd0);
      checkOutput("reset_err", 32'(err_o), 32'd0);
      checkOutput("reset_rdata", rdata_o, 32'd0);
      checkOutput("reset_maddr", mem_addr_o, 32'd0);
      checkOutput("reset_mwdata", mem_wdata_o, 32'd0);
      checkOutput("reset_strobes", 32'({mem_re_o, mem_we_o}), 32'd0);

      for (int i = 0; i < 64; i++) poke(i, $urandom);

      poke(0, 32'h1122_3344);
      applyStimulus(1'b1, 4'd0, 32'h102, 32'h0000_00AB, 1'b0);
      drain();

      applyReset();
      poke(0, 32'h8022_3344);
      applyStimulus(1'b0, 4'd0, 32'h103, 32'h0, 1'b0);
      applyStimulus(1'b0, 4'd4, 32'h103, 32'h0, 1'b0);
      applyStimulus(1'b0, 4'd1, 32'h102, 32'h0, 1'b0);
      applyStimulus(1'b1, 4'd2, 32'h104, 32'hDEAD_BEEF, 1'b0);
      applyStimulus(1'b1, 4'd1, 32'h101, 32'h1234_5678, 1'b0);
      applyStimulus(1'b0, 4'd3, 32'h100, 32'h0, 1'b0);
      applyStimulus(1'b1, 4'd4, 32'h100, 32'h0000_0099, 1'b0);

      applyStimulus(1'b1, 4'd0, 32'h100, 32'h0000_0055, 1'b0);
      applyStimulus(1'b1, 4'd0, 32'h101, 32'h0000_0066, 1'b0);
      drain();
      applyReset();
      applyStimulus(1'b1, 4'd0, 32'h101, 32'h0000_0077, 1'b0);

      // Request held high through DONE must not be re-accepted until IDLE
      applyStimulus(1'b0, 4'd3, 32'h100, 32'h0, 1'b1);
      applyStimulus(1'b0, 4'd2, 32'h100, 32'h0, 1'b1);
      applyStimulus(1'b0, 4'd5, 32'h106, 32'h0, 1'b0);
      drain();

      // Reset during the read half of an RMW store aborts it without a write
      we_before = we_total;
      @(negedge clk_i);
      we_i = 1'b1; funct_i = 4'd0; addr_i = 32'h108; wdata_i = 32'h0000_00CC; req_i = 1'b1;
      @(posedge clk_i);
      #1;
      req_i = 1'b0;
      rst_i = 1'b1;
      @(negedge clk_i);
      checkOutput("rst_rd_re", 32'(mem_re_o), 32'd0);
      checkOutput("rst_rd_we", 32'(mem_we_o), 32'd0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      c_valid    = 1'b0;
      last_rdata = '0;
      @(negedge clk_i);
      checkOutput("rst_rd_ready", 32'(ready_o), 32'd1);
      checkOutput("rst_rd_rdata", rdata_o, 32'd0);
      checkOutput("rst_rd_maddr", mem_addr_o, 32'd0);
      repeat (4) @(negedge clk_i);
      checkOutput("rst_rd_no_write", 32'(we_total), 32'(we_before));

      for (int k = 0; k < 300; k++) begin
         r = int'($urandom_range(0, 9));
         case (r)
            0, 1:    f = 4'd0;
            2, 3:    f = 4'd1;
            4, 5:    f = 4'd2;
            6:       f = 4'd4;
            7:       f = 4'd5;
            default: f = 4'($urandom_range(0, 15));
         endcase
         if ($urandom_range(0, 1) == 1) a = 32'h100 + 32'($urandom_range(0, 15));
         else                           a = 32'h100 + 32'($urandom_range(0, 255));
         applyStimulus(1'($urandom_range(0, 1)), f, a, $urandom, ($urandom_range(0, 3) == 0));
      end
      drain();

      for (int i = 0; i < 64; i++) checkOutput("ram_final", ram[i], ref_mem[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
